// File: rtl/axis_diff_sequencer.sv
// Sequencer around the axis_differentiator: decimates input, flushes history,
// blanks the start-up transient and counts output beats lost to backpressure.
module axis_diff_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int FLUSH_LEN        = 5,
  parameter int PRIME_LEN        = 3,
  parameter int DECIM_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [DECIM_WIDTH-1:0]      decimation,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  output logic                        D_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] D_AXIS_tdata,
  input  logic                        R_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] R_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [1:0]                  state,
  output logic [15:0]                 overflow_count
);

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int PW = (PRIME_LEN > 1) ? $clog2(PRIME_LEN) : 1;
  localparam int FL = FLUSH_LEN - 1;
  localparam int PL = (PRIME_LEN > 0) ? PRIME_LEN - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [FW-1:0]               r_fcnt;
  logic [PW-1:0]               r_pcnt;
  logic [DECIM_WIDTH-1:0]      r_dcnt;
  logic [DECIM_WIDTH-1:0]      r_dec;
  logic                        r_d_valid;
  logic [AXIS_TDATA_WIDTH-1:0] r_d_data;
  logic                        r_m_valid;
  logic [AXIS_TDATA_WIDTH-1:0] r_m_data;
  logic [15:0]                 r_ovf;
  logic                        w_active;
  logic                        w_fwd;
  logic                        w_start;
  logic                        w_m_fire;

  assign w_active = (r_state == ST_PRIME) || (r_state == ST_RUN);
  assign w_fwd    = w_active && S_AXIS_tvalid && (r_dcnt == r_dec) &&
                    (w_next != ST_IDLE);
  assign w_start  = (r_state == ST_IDLE) && (w_next == ST_FLUSH);
  assign w_m_fire = R_AXIS_tvalid && (r_state == ST_RUN) && enable;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!enable) w_next = ST_IDLE;
        else if (r_fcnt == FW'(FL))
          w_next = (PRIME_LEN == 0) ? ST_RUN : ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable) w_next = ST_IDLE;
        else if (R_AXIS_tvalid && (r_pcnt == PW'(PL)))
          w_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_fcnt    <= '0;
      r_pcnt    <= '0;
      r_dcnt    <= '0;
      r_dec     <= '0;
      r_d_valid <= 1'b0;
      r_d_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_ovf     <= '0;
    end else begin
      r_state <= w_next;

      if (w_start) begin
        r_dec  <= decimation;
        r_fcnt <= '0;
      end else if (r_state == ST_FLUSH) begin
        r_fcnt <= r_fcnt + 1'b1;
      end

      if (r_state != ST_PRIME) r_pcnt <= '0;
      else if (R_AXIS_tvalid)  r_pcnt <= r_pcnt + 1'b1;

      // Phase restarts on every PRIME/RUN entry
      if (w_next != r_state) r_dcnt <= '0;
      else if (w_active && S_AXIS_tvalid)
        r_dcnt <= (r_dcnt == r_dec) ? '0 : r_dcnt + 1'b1;

      r_d_valid <= (w_next == ST_FLUSH) || w_fwd;
      if (w_next == ST_FLUSH) r_d_data <= '0;
      else if (w_fwd)         r_d_data <= S_AXIS_tdata;

      r_m_valid <= w_m_fire;
      if (w_m_fire) r_m_data <= R_AXIS_tdata;

      if (w_start) r_ovf <= '0;
      else if (r_m_valid && !M_AXIS_tready && (r_ovf != 16'hFFFF))
        r_ovf <= r_ovf + 16'd1;
    end
  end

  assign S_AXIS_tready  = 1'b1;
  assign D_AXIS_tvalid  = r_d_valid;
  assign D_AXIS_tdata   = r_d_data;
  assign M_AXIS_tvalid  = r_m_valid;
  assign M_AXIS_tdata   = r_m_data;
  assign state          = r_state;
  assign overflow_count = r_ovf;

endmodule

// File: tb/tb_axis_diff_sequencer.sv
// Scoreboard bench for axis_diff_sequencer: directed stimulus pushes
// expected D/M beats, a negedge monitor pops and compares them.
module tb_axis_diff_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [15:0] decimation;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        d_valid;
  logic [15:0] d_data;
  logic        r_valid;
  logic [15:0] r_data;
  logic        m_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic [1:0]  st;
  logic [15:0] ovf;

  logic        mirror;
  logic        tb_r_valid;
  logic [15:0] tb_r_data;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_d[$];
  logic [15:0] exp_m[$];

  always #5 aclk = ~aclk;

  // Differentiator stand-in: R follows D with no delay in mirror mode
  assign r_valid = mirror ? d_valid : tb_r_valid;
  assign r_data  = mirror ? d_data  : tb_r_data;

  axis_diff_sequencer dut (
    .aclk           (aclk),
    .areset         (areset),
    .enable         (enable),
    .decimation     (decimation),
    .S_AXIS_tvalid  (s_valid),
    .S_AXIS_tdata   (s_data),
    .S_AXIS_tready  (s_ready),
    .D_AXIS_tvalid  (d_valid),
    .D_AXIS_tdata   (d_data),
    .R_AXIS_tvalid  (r_valid),
    .R_AXIS_tdata   (r_data),
    .M_AXIS_tready  (m_ready),
    .M_AXIS_tvalid  (m_valid),
    .M_AXIS_tdata   (m_data),
    .state          (st),
    .overflow_count (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_d(input logic [15:0] v);
    exp_d.push_back(v);
  endtask

  task automatic push_m(input logic [15:0] v);
    exp_m.push_back(v);
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (d_valid) begin
        if (exp_d.size() == 0) begin
          total++; bad++;
          $display("FAIL d_unexpected actual=%0h required=none", d_data);
        end else begin
          chk("d_beat", d_data, exp_d.pop_front());
        end
      end
      if (m_valid) begin
        if (exp_m.size() == 0) begin
          total++; bad++;
          $display("FAIL m_unexpected actual=%0h required=none", m_data);
        end else begin
          chk("m_beat", m_data, exp_m.pop_front());
        end
      end
    end
  end

  task automatic start_run(input logic [15:0] dec);
    mirror     = 1'b0;
    decimation = dec;
    for (int i = 0; i < 5; i++) push_d(16'h0);
    enable = 1'b1;
    repeat (6) tick();
    chk("sr_prime", st, 2);
    for (int i = 0; i < 3; i++) begin
      tb_r_valid = 1'b1;
      tb_r_data  = 16'(50 + i);
      tick();
    end
    tb_r_valid = 1'b0;
    chk("sr_run", st, 3);
  endtask

  initial begin
    areset = 1'b1; enable = 1'b0; decimation = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    mirror = 1'b0; tb_r_valid = 1'b0; tb_r_data = '0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_state", st, 0);
    chk("rst_dvalid", d_valid, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("tready", s_ready, 1);
    areset = 1'b0;
    tick();

    // Flush: S samples during FLUSH must never reach D
    s_valid = 1'b1; s_data = 16'hABCD;
    for (int i = 0; i < 5; i++) push_d(16'h0);
    enable = 1'b1;
    tick();
    chk("flush_enter", st, 1);
    chk("flush_d0", {d_valid, d_data}, {1'b1, 16'h0});
    repeat (4) tick();
    chk("flush_last", st, 1);
    tick();
    chk("prime_enter", st, 2);
    s_valid = 1'b0;

    // Prime: first three R beats blanked, fourth appears on M
    push_m(16'd13);
    for (int d = 10; d <= 13; d++) begin
      tb_r_valid = 1'b1;
      tb_r_data  = 16'(d);
      tick();
      if (d == 12) chk("run_enter", st, 3);
      if (d == 13) chk("m_lat", {m_valid, m_data}, {1'b1, 16'd13});
    end
    tb_r_valid = 1'b0;
    tick();

    // Decimation 0: every sample forwarded one cycle later
    mirror = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      push_d(16'(i));
      push_m(16'(i));
      tick();
      if (i == 1) chk("d_lat", {d_valid, d_data}, {1'b1, 16'd1});
    end
    s_valid = 1'b0;
    repeat (3) tick();

    enable = 1'b0;
    tick();
    chk("dis_state", st, 0);
    chk("dis_dvalid", d_valid, 0);

    // Decimation 3: only every fourth sample
    start_run(16'd3);
    mirror = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      if (i % 4 == 0) begin
        push_d(16'(i));
        push_m(16'(i));
      end
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();

    // Overflow counting and saturation
    mirror  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tb_r_valid = 1'b1;
      tb_r_data  = 16'(200 + i);
      push_m(16'(200 + i));
      tick();
    end
    tb_r_valid = 1'b0;
    repeat (2) tick();
    chk("ovf_10", ovf, 10);
    force dut.r_ovf = 16'hFFFE;
    #1;
    release dut.r_ovf;
    #1;
    chk("ovf_forced", ovf, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tb_r_valid = 1'b1;
      tb_r_data  = 16'(300 + i);
      push_m(16'(300 + i));
      tick();
    end
    tb_r_valid = 1'b0;
    repeat (2) tick();
    chk("ovf_sat", ovf, 16'hFFFF);
    m_ready = 1'b1;

    // Enable dropped on the third FLUSH beat
    enable = 1'b0;
    tick();
    chk("idle2", st, 0);
    for (int i = 0; i < 3; i++) push_d(16'h0);
    enable = 1'b1;
    tick();
    chk("ovf_clr", ovf, 0);
    repeat (2) tick();
    chk("flush3_d", d_valid, 1);
    enable = 1'b0;
    tick();
    chk("abort_state", st, 0);
    chk("abort_dvalid", d_valid, 0);
    for (int i = 0; i < 5; i++) push_d(16'h0);
    enable = 1'b1;
    repeat (5) tick();
    chk("reflush", st, 1);
    tick();
    chk("reprime", st, 2);

    // Reset asserted mid-RUN
    for (int i = 0; i < 3; i++) begin
      tb_r_valid = 1'b1;
      tb_r_data  = 16'(60 + i);
      tick();
    end
    chk("run3", st, 3);
    m_ready   = 1'b0;
    tb_r_data = 16'd77;
    push_m(16'd77);
    tick();
    tb_r_data = 16'd88;
    tick();
    chk("pre_rst_m", m_valid, 1);
    chk("pre_rst_ovf", ovf, 1);
    #1;
    areset = 1'b1;
    enable = 1'b0;
    tb_r_valid = 1'b0;
    #1;
    chk("ar_state", st, 0);
    chk("ar_dvalid", d_valid, 0);
    chk("ar_mvalid", m_valid, 0);
    chk("ar_ovf", ovf, 0);
    tick();
    areset = 1'b0;
    tick();

    chk("d_queue_empty", exp_d.size(), 0);
    chk("m_queue_empty", exp_m.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
